color_centroid_tracker: RTL and testbench



---
 rtl/centroid_pkg.sv | 9 +
 rtl/seq_divider.sv | 47 ++++
 rtl/color_centroid_tracker.sv | 139 +++++++++++++
 tb/tb_color_centroid_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// centroid_pkg: shared widths, tracker FSM states and overlay colour
package centroid_pkg;
  localparam int COORD_W = 10;
  localparam int PIX_W = 8;
  localparam int CNT_W = 19;
  localparam int SUM_W = 29;
  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;
  localparam logic [3*PIX_W-1:0] OVERLAY_RGB = {PIX_W'(0), {PIX_W{1'b1}}, PIX_W'(0)};
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, done pulses after DVD_W cycles
module seq_divider
  import centroid_pkg::*;
#(
  parameter int DVD_W = SUM_W,
  parameter int DVS_W = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(DVD_W + 1);
  logic [DVS_W-1:0] rem, div_r, cur_rem, cur_div, rem_n;
  logic [DVD_W-1:0] cur_q;
  logic [DVS_W:0] shifted;
  logic [CW-1:0] cnt;
  logic ge, step;
  always_comb begin
    cur_rem = start ? '0 : rem;
    cur_q = start ? dividend : quotient;
    cur_div = start ? divisor : div_r;
    shifted = {cur_rem, cur_q[DVD_W-1]};
    ge = shifted >= {1'b0, cur_div};
    rem_n = ge ? DVS_W'(shifted - {1'b0, cur_div}) : DVS_W'(shifted);
    step = start | (cnt != '0 && cnt != CW'(DVD_W));
  end
  assign done = cnt == CW'(DVD_W);
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      div_r <= '0;
      quotient <= '0;
      cnt <= '0;
    end else begin
      if (step) begin
        rem <= rem_n;
        quotient <= {cur_q[DVD_W-2:0], ge};
        div_r <= cur_div;
      end
      cnt <= start ? CW'(1) : done ? '0 : step ? cnt + CW'(1) : cnt;
    end
  end
endmodule

// File: rtl/color_centroid_tracker.sv
// color_centroid_tracker: per-frame colour-window centroid/bbox tracker; CENTROID_OVERLAY_EN adds ov_r/ov_g/ov_b overlay outputs
module color_centroid_tracker
  import centroid_pkg::*;
#(
  parameter int MIN_PIXELS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               vsync_n,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [PIX_W-1:0]   pix_r,
  input  logic [PIX_W-1:0]   pix_g,
  input  logic [PIX_W-1:0]   pix_b,
  input  logic [PIX_W-1:0]   r_min,
  input  logic [PIX_W-1:0]   g_max,
  input  logic [PIX_W-1:0]   b_max,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] bb_x0,
  output logic [COORD_W-1:0] bb_y0,
  output logic [COORD_W-1:0] bb_x1,
  output logic [COORD_W-1:0] bb_y1,
  output logic [CNT_W-1:0]   pix_count,
  output logic               found,
  output logic               result_valid,
  output logic               busy,
  output logic               overrun
`ifdef CENTROID_OVERLAY_EN
  ,
  output logic [PIX_W-1:0]   ov_r,
  output logic [PIX_W-1:0]   ov_g,
  output logic [PIX_W-1:0]   ov_b
`endif
);
  state_t state, state_n;
  logic vs_d, frame_end, match, div_start, div_done, found_n;
  logic [SUM_W-1:0] div_dvd, quotient, a_sx, a_sy, b_sx, b_sy, w_sy;
  logic [CNT_W-1:0] div_dvs, a_cnt, b_cnt, w_cnt;
  logic [COORD_W-1:0] a_x0, a_x1, a_y0, a_y1, b_x0, b_x1, b_y0, b_y1;
  logic [COORD_W-1:0] w_x0, w_x1, w_y0, w_y1, qx;
  assign frame_end = vs_d & ~vsync_n;
  assign match = pix_valid & (pix_r >= r_min) & (pix_g <= g_max) & (pix_b <= b_max);
  assign found_n = w_cnt >= CNT_W'(MIN_PIXELS);
  always_ff @(posedge clk) state <= reset ? ACCUM : state_n;
  always_comb begin
    state_n = (state == ACCUM && frame_end) ? DIV_X :
              (state == DIV_X && div_done) ? DIV_Y :
              (state == DIV_Y && div_done) ? PUBLISH :
              (state == PUBLISH) ? ACCUM : state;
  end
  always_comb begin
    busy = state != ACCUM;
    div_start = (state == ACCUM && frame_end) || (state == DIV_X && div_done);
    div_dvd = state == ACCUM ? a_sx : w_sy;
    div_dvs = state == ACCUM ? a_cnt : w_cnt;
  end
  seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W)) u_div (
    .clk(clk),
    .reset(reset),
    .start(div_start),
    .dividend(div_dvd),
    .divisor(div_dvs),
    .quotient(quotient),
    .done(div_done)
  );
  // a frame end restarts the accumulators, so a match in that same cycle opens the new frame
  always_comb begin
    b_cnt = frame_end ? '0 : a_cnt;
    b_sx = frame_end ? '0 : a_sx;
    b_sy = frame_end ? '0 : a_sy;
    b_x0 = frame_end ? '1 : a_x0;
    b_x1 = frame_end ? '0 : a_x1;
    b_y0 = frame_end ? '1 : a_y0;
    b_y1 = frame_end ? '0 : a_y1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt <= '0;
      a_sx <= '0;
      a_sy <= '0;
      a_x0 <= '1;
      a_x1 <= '0;
      a_y0 <= '1;
      a_y1 <= '0;
    end else begin
      a_cnt <= b_cnt + CNT_W'(match);
      a_sx <= b_sx + (match ? SUM_W'(col) : '0);
      a_sy <= b_sy + (match ? SUM_W'(row) : '0);
      a_x0 <= match && col < b_x0 ? col : b_x0;
      a_x1 <= match && col > b_x1 ? col : b_x1;
      a_y0 <= match && row < b_y0 ? row : b_y0;
      a_y1 <= match && row > b_y1 ? row : b_y1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d <= 1'b0;
      {w_cnt, w_sy, w_x0, w_x1, w_y0, w_y1, qx} <= '0;
      {cx, cy, bb_x0, bb_y0, bb_x1, bb_y1, pix_count} <= '0;
      found <= 1'b0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vs_d <= vsync_n;
      result_valid <= state == PUBLISH;
      if (frame_end && busy) overrun <= 1'b1;
      if (state == ACCUM && frame_end) begin
        w_cnt <= a_cnt;
        w_sy <= a_sy;
        {w_x0, w_x1, w_y0, w_y1} <= {a_x0, a_x1, a_y0, a_y1};
      end
      if (state == DIV_X && div_done) qx <= COORD_W'(quotient);
      if (state == PUBLISH) begin
        pix_count <= w_cnt;
        found <= found_n;
        if (found_n) begin
          cx <= qx;
          cy <= COORD_W'(quotient);
          {bb_x0, bb_x1, bb_y0, bb_y1} <= {w_x0, w_x1, w_y0, w_y1};
        end
      end
    end
  end
`ifdef CENTROID_OVERLAY_EN
  logic in_x, in_y, hit;
  always_comb begin
    in_x = col >= bb_x0 && col <= bb_x1;
    in_y = row >= bb_y0 && row <= bb_y1;
    hit = found && (col == cx || row == cy || ((col == bb_x0 || col == bb_x1) && in_y) ||
                    ((row == bb_y0 || row == bb_y1) && in_x));
  end
  always_ff @(posedge clk) begin
    if (reset) {ov_r, ov_g, ov_b} <= '0;
    else {ov_r, ov_g, ov_b} <= hit ? OVERLAY_RGB : {pix_r, pix_g, pix_b};
  end
`endif
endmodule

// File: tb/tb_color_centroid_tracker.sv
// tb_color_centroid_tracker: randomized and directed frames checked against a queue-based frame model
module tb_color_centroid_tracker;
  import centroid_pkg::*;
  localparam int LAT = 60;
  localparam int MINP = 64;
  logic clk = 0, reset = 1, pix_valid = 0, vsync_n = 1;
  logic [COORD_W-1:0] row = '0, col = '0;
  logic [PIX_W-1:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic [PIX_W-1:0] r_min = 8'd200, g_max = 8'd60, b_max = 8'd60;
  logic [COORD_W-1:0] cx, cy, bb_x0, bb_y0, bb_x1, bb_y1;
  logic [CNT_W-1:0] pix_count;
  logic found, result_valid, busy, overrun;
  color_centroid_tracker #(.MIN_PIXELS(MINP)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .vsync_n(vsync_n),
    .row(row), .col(col), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .r_min(r_min), .g_max(g_max), .b_max(b_max),
    .cx(cx), .cy(cy), .bb_x0(bb_x0), .bb_y0(bb_y0), .bb_x1(bb_x1), .bb_y1(bb_y1),
    .pix_count(pix_count), .found(found), .result_valid(result_valid),
    .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  typedef struct {int x; int y;} pt_t;
  pt_t acc_q[$], snap_q[$];
  int timer = 0;
  bit prev_vs = 0, started = 0;
  int e_cx = 0, e_cy = 0, e_x0 = 0, e_y0 = 0, e_x1 = 0, e_y1 = 0, e_cnt = 0;
  bit e_found = 0, e_rv = 0, e_busy = 0, e_ovr = 0;
  function automatic void publish();
    longint sx = 0, sy = 0;
    int x0 = 1 << 30, x1 = 0, y0 = 1 << 30, y1 = 0;
    e_cnt = snap_q.size();
    e_found = e_cnt >= MINP;
    foreach (snap_q[i]) begin
      sx += snap_q[i].x;
      sy += snap_q[i].y;
      if (snap_q[i].x < x0) x0 = snap_q[i].x;
      if (snap_q[i].x > x1) x1 = snap_q[i].x;
      if (snap_q[i].y < y0) y0 = snap_q[i].y;
      if (snap_q[i].y > y1) y1 = snap_q[i].y;
    end
    if (e_found) begin
      e_cx = int'(sx / e_cnt);
      e_cy = int'(sy / e_cnt);
      e_x0 = x0;
      e_x1 = x1;
      e_y0 = y0;
      e_y1 = y1;
    end
  endfunction
  // frame-level model: a collected frame is published LAT cycles after its vsync fall
  always @(posedge clk) begin
    bit fe, m, busy_now;
    if (reset) begin
      acc_q.delete();
      snap_q.delete();
      timer = 0;
      prev_vs = 0;
      {e_cx, e_cy, e_x0, e_y0, e_x1, e_y1, e_cnt} = '0;
      {e_found, e_rv, e_busy, e_ovr} = '0;
      started = 1;
    end else begin
      fe = prev_vs && !vsync_n;
      prev_vs = vsync_n;
      m = pix_valid && pix_r >= r_min && pix_g <= g_max && pix_b <= b_max;
      busy_now = timer != 0;
      e_rv = 0;
      if (timer != 0) begin
        timer++;
        if (timer == LAT) begin
          publish();
          e_rv = 1;
          timer = 0;
        end
      end
      if (fe) begin
        if (busy_now) e_ovr = 1;
        else begin
          snap_q = acc_q;
          timer = 1;
        end
        acc_q.delete();
      end
      if (m) acc_q.push_back('{int'(col), int'(row)});
      e_busy = timer != 0;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("cx", cx, e_cx);
      chk("cy", cy, e_cy);
      chk("bb_x0", bb_x0, e_x0);
      chk("bb_y0", bb_y0, e_y0);
      chk("bb_x1", bb_x1, e_x1);
      chk("bb_y1", bb_y1, e_y1);
      chk("pix_count", pix_count, e_cnt);
      chk("found", found, e_found);
      chk("result_valid", result_valid, e_rv);
      chk("busy", busy, e_busy);
      chk("overrun", overrun, e_ovr);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic px(input int c, input int r, input bit hit);
    pix_valid = 1;
    col = COORD_W'(c);
    row = COORD_W'(r);
    {pix_r, pix_g, pix_b} = hit ? {8'd255, 8'd0, 8'd0} : {8'd10, 8'd200, 8'd200};
    tick();
    pix_valid = 0;
  endtask
  task automatic px_rand();
    pix_valid = $urandom_range(0, 3) != 0;
    col = COORD_W'($urandom_range(0, 639));
    row = COORD_W'($urandom_range(0, 479));
    pix_r = PIX_W'($urandom_range(150, 255));
    pix_g = PIX_W'($urandom_range(0, 70));
    pix_b = PIX_W'($urandom_range(0, 70));
    tick();
    pix_valid = 0;
  endtask
  task automatic vs_fall();
    vsync_n = 0;
    tick();
    vsync_n = 1;
  endtask
  task automatic vs_fall_hit();
    pix_valid = 1;
    col = 10'd7;
    row = 10'd9;
    {pix_r, pix_g, pix_b} = {8'd255, 8'd0, 8'd0};
    vs_fall();
    pix_valid = 0;
  endtask
  task automatic wait_rv(input int from, output int lat);
    lat = -1;
    for (int k = from; k <= from + 100; k++) begin
      if (result_valid) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask
  initial begin
    int lat, n_rv;
    repeat (3) tick();
    reset = 0;
    repeat (2) tick();
    for (int r = 200; r < 210; r++)
      for (int c = 100; c < 110; c++) px(c, r, 1);
    px(5, 5, 0);
    px(600, 400, 0);
    vs_fall();
    wait_rv(1, lat);
    chk("t1_latency", lat, 60);
    chk("t1_pix_count", pix_count, 100);
    chk("t1_cx", cx, 104);
    chk("t1_cy", cy, 204);
    chk("t1_bb_x0", bb_x0, 100);
    chk("t1_bb_y0", bb_y0, 200);
    chk("t1_bb_x1", bb_x1, 109);
    chk("t1_bb_y1", bb_y1, 209);
    chk("t1_found", found, 1);
    tick();
    for (int i = 0; i < 50; i++) px(300 + i, 10, 1);
    vs_fall();
    wait_rv(1, lat);
    chk("t2_pix_count", pix_count, 50);
    chk("t2_found", found, 0);
    chk("t2_cx_held", cx, 104);
    chk("t2_cy_held", cy, 204);
    chk("t2_bb_x0_held", bb_x0, 100);
    tick();
    for (int i = 0; i < MINP; i++) px(639, 479, 1);
    vs_fall();
    wait_rv(1, lat);
    chk("t3_cx", cx, 639);
    chk("t3_cy", cy, 479);
    chk("t3_bb_x0", bb_x0, 639);
    chk("t3_bb_x1", bb_x1, 639);
    chk("t3_bb_y0", bb_y0, 479);
    chk("t3_bb_y1", bb_y1, 479);
    chk("t3_found", found, 1);
    tick();
    for (int i = 0; i < 70; i++) px(i, 50 + i % 7, 1);
    vs_fall();
    repeat (19) tick();
    vs_fall();
    chk("t4_overrun", overrun, 1);
    wait_rv(21, lat);
    chk("t4_latency", lat, 60);
    chk("t4_pix_count", pix_count, 70);
    tick();
    for (int i = 0; i < 80; i++) px(10 + i, 20, 1);
    vs_fall();
    wait_rv(1, lat);
    chk("t4_next_pix_count", pix_count, 80);
    chk("t4_next_cx", cx, 49);
    chk("t4_next_cy", cy, 20);
    tick();
    for (int i = 0; i < 100; i++) px(50 + i % 10, 60 + i / 10, 1);
    vs_fall();
    repeat (29) tick();
    reset = 1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_cx", cx, 0);
    chk("t5_bb_y1", bb_y1, 0);
    chk("t5_pix_count", pix_count, 0);
    chk("t5_overrun", overrun, 0);
    reset = 0;
    n_rv = 0;
    repeat (80) begin
      if (result_valid) n_rv++;
      tick();
    end
    chk("t5_no_result", n_rv, 0);
    for (int i = 0; i < 90; i++) px(50 + i % 10, 60 + i / 10, 1);
    vs_fall();
    repeat (34) tick();
    for (int i = 0; i < 5; i++) px(400 + i, 300, 1);
    wait_rv(40, lat);
    chk("t6_latency", lat, 60);
    chk("t6_pix_count", pix_count, 90);
    tick();
    vs_fall();
    wait_rv(1, lat);
    chk("t6_next_pix_count", pix_count, 5);
    chk("t6_next_found", found, 0);
    tick();
    for (int f = 0; f < 10; f++) begin
      r_min = PIX_W'($urandom_range(170, 230));
      repeat ($urandom_range(0, 400)) px_rand();
      if ($urandom_range(0, 1) != 0) vs_fall_hit();
      else vs_fall();
      repeat ($urandom_range(0, 70)) px_rand();
      if ($urandom_range(0, 2) == 0) vs_fall();
    end
    repeat (70) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
